// File: rtl/reaction_timer_n.sv
// Reaction-time game: random pre-stimulus delay, then the led lights and time_ms
// counts milliseconds until the player presses stop. Keeps the best score since reset.
module reaction_timer_n #(
  parameter int TICK_CYCLES     = 100000,
  parameter int TW              = 10,
  parameter int MAX_MS          = 1000,
  parameter int DELAY_MIN_MS    = 2000,
  parameter int DELAY_SPAN_LOG2 = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          clear,
  output logic          led,
  output logic [TW-1:0] time_ms,
  output logic [TW-1:0] best_ms,
  output logic [2:0]    state_o,
  output logic          busy
);

  localparam int TCW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int DW  = $clog2(DELAY_MIN_MS + (1 << DELAY_SPAN_LOG2) + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_RUN     = 3'd2,
    S_DONE    = 3'd3,
    S_FAULT   = 3'd4,
    S_TIMEOUT = 3'd5
  } state_t;

  state_t          state, state_nx;
  logic            led_nx, busy_nx;
  logic [15:0]     lfsr;
  logic [TCW-1:0]  tick_cnt;
  logic [DW-1:0]   delay_cnt;
  logic            tick, wait_done, run_timeout, enter_timed;

  assign tick        = (tick_cnt == TCW'(TICK_CYCLES - 1));
  assign wait_done   = tick && (delay_cnt <= DW'(1));
  assign run_timeout = tick && (time_ms == TW'(MAX_MS - 1));
  assign enter_timed = (state_nx != state) && (state_nx == S_WAIT || state_nx == S_RUN);
  assign state_o     = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      led   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      led   <= led_nx;
      busy  <= busy_nx;
    end
  end

  // Priority clear > stop > start; a timeout tick beats a coincident stop.
  always_comb begin
    state_nx = state;
    if (clear) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_FAULT, S_TIMEOUT: if (start) state_nx = S_WAIT;
        S_WAIT: begin
          if (stop)           state_nx = S_FAULT;
          else if (wait_done) state_nx = S_RUN;
        end
        S_RUN: begin
          if (run_timeout) state_nx = S_TIMEOUT;
          else if (stop)   state_nx = S_DONE;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    led_nx  = (state_nx == S_RUN);
    busy_nx = (state_nx == S_WAIT) || (state_nx == S_RUN);
  end

  // Taps 16,14,13,11 in shift-right form; a nonzero seed never reaches zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr <= 16'hACE1;
    else      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                                  tick_cnt <= '0;
    else if (enter_timed || !(state_nx == S_WAIT || state_nx == S_RUN)) tick_cnt <= '0;
    else if (tick)                                             tick_cnt <= '0;
    else                                                       tick_cnt <= tick_cnt + TCW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      delay_cnt <= '0;
    else if (state_nx == S_WAIT && state != S_WAIT)
      delay_cnt <= DW'(DELAY_MIN_MS) + DW'(lfsr[DELAY_SPAN_LOG2-1:0]);
    else if (state_nx != S_WAIT)
      delay_cnt <= '0;
    else if (tick)
      delay_cnt <= delay_cnt - DW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      time_ms <= '0;
      best_ms <= '1;
    end else if (clear) begin
      time_ms <= '0;
    end else if (state == S_RUN) begin
      if (run_timeout) begin
        time_ms <= TW'(MAX_MS);
      end else if (stop) begin
        if (time_ms < best_ms) best_ms <= time_ms;
      end else if (tick) begin
        time_ms <= time_ms + TW'(1);
      end
    end else if (state != S_WAIT && start) begin
      time_ms <= '0;
    end
  end

endmodule

// File: tb/tb_reaction_timer_n.sv
// Directed trials plus random pulses, checked every cycle against a cycle-count model.
module tb_reaction_timer_n;
  localparam int TICK = 4, TW = 10, MAX = 20, DMIN = 3, SPAN = 2;
  localparam int NONE = (1 << TW) - 1;
  localparam int ST_IDLE = 0, ST_WAIT = 1, ST_RUN = 2, ST_DONE = 3, ST_FAULT = 4, ST_TO = 5;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, clear = 1'b0;
  logic led, busy;
  logic [TW-1:0] time_ms, best_ms;
  logic [2:0] state_o;
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  reaction_timer_n #(
    .TICK_CYCLES(TICK), .TW(TW), .MAX_MS(MAX), .DELAY_MIN_MS(DMIN), .DELAY_SPAN_LOG2(SPAN)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .led(led), .time_ms(time_ms), .best_ms(best_ms), .state_o(state_o), .busy(busy)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference: WAIT lasts delay*TICK cycles, RUN time is elapsed cycles / TICK.
  int m_st, m_time, m_best, m_wait_left, m_run_n;
  logic [15:0] m_lfsr;

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    logic [15:0] b;
    b = (x ^ (x >> 2) ^ (x >> 3) ^ (x >> 5)) & 16'h1;
    return (x >> 1) | (b << 15);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_st <= ST_IDLE; m_time <= 0; m_best <= NONE;
      m_wait_left <= 0; m_run_n <= 0; m_lfsr <= 16'hACE1;
    end else begin
      m_lfsr <= lfsr_step(m_lfsr);
      if (clear) begin
        m_st <= ST_IDLE; m_time <= 0;
      end else case (m_st)
        ST_WAIT: begin
          if (stop) m_st <= ST_FAULT;
          else if (m_wait_left == 1) begin m_st <= ST_RUN; m_run_n <= 0; end
          else m_wait_left <= m_wait_left - 1;
        end
        ST_RUN: begin
          if (m_run_n + 1 == MAX * TICK) begin
            m_st <= ST_TO; m_time <= MAX;
          end else if (stop) begin
            m_st <= ST_DONE;
            if (m_run_n / TICK < m_best) m_best <= m_run_n / TICK;
          end else begin
            m_run_n <= m_run_n + 1;
            m_time  <= (m_run_n + 1) / TICK;
          end
        end
        default: if (start) begin
          m_st <= ST_WAIT; m_time <= 0;
          m_wait_left <= (DMIN + (int'(m_lfsr) % (1 << SPAN))) * TICK;
        end
      endcase
    end
  end

  always @(posedge clk) begin
    #3;
    chk("state", int'(state_o), m_st);
    chk("time", int'(time_ms), m_time);
    chk("best", int'(best_ms), m_best);
    chk("led", int'(led), int'(m_st == ST_RUN));
    chk("busy", int'(busy), int'(m_st == ST_WAIT || m_st == ST_RUN));
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic start_and_wait_led();
    int w;
    pulse_start();
    w = 0;
    while (!led && w < 60) begin @(negedge clk); w++; end
    chk("led_rise", int'(led), 1);
    chk("delay_in_range", int'(w % TICK == 0 && w / TICK >= DMIN && w / TICK <= DMIN + 3), 1);
  endtask

  task automatic stop_after(input int ticks);
    repeat (ticks * TICK) @(negedge clk);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, int'(state_o), ST_IDLE);
    chk({tag, "_led"}, int'(led), 0);
    chk({tag, "_time"}, int'(time_ms), 0);
    chk({tag, "_best"}, int'(best_ms), NONE);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    int hi, cnt;
    #1 rst = 1'b0;
    #1 chk_reset_vals("rst0");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    start_and_wait_led(); stop_after(7);
    chk("t1_state", int'(state_o), ST_DONE); chk("t1_time", int'(time_ms), 7);
    chk("t1_best", int'(best_ms), 7);        chk("t1_led", int'(led), 0);
    start_and_wait_led(); stop_after(5);
    chk("t2_time", int'(time_ms), 5); chk("t2_best", int'(best_ms), 5);
    start_and_wait_led(); stop_after(9);
    chk("t3_time", int'(time_ms), 9); chk("t3_best", int'(best_ms), 5);

    pulse_start();
    hi = 0;
    repeat (2) begin if (led) hi++; @(negedge clk); end
    stop = 1'b1; @(negedge clk); stop = 1'b0;
    chk("fault_state", int'(state_o), ST_FAULT); chk("fault_time", int'(time_ms), 0);
    chk("fault_best", int'(best_ms), 5);         chk("fault_led", hi + int'(led), 0);

    start_and_wait_led();
    cnt = 0;
    while (state_o != 3'(ST_TO) && cnt < 100) begin @(negedge clk); cnt++; end
    chk("to_cycles", cnt, MAX * TICK); chk("to_time", int'(time_ms), MAX);
    chk("to_best", int'(best_ms), 5);    chk("to_led", int'(led), 0);

    start_and_wait_led();
    repeat (6) @(negedge clk);
    clear = 1'b1; stop = 1'b1; @(negedge clk); clear = 1'b0; stop = 1'b0;
    chk("clr_state", int'(state_o), ST_IDLE); chk("clr_time", int'(time_ms), 0);
    chk("clr_best", int'(best_ms), 5);        chk("clr_led", int'(led), 0);

    start_and_wait_led();
    repeat (8) @(negedge clk);
    stop = 1'b1; start = 1'b1; @(negedge clk); stop = 1'b0; start = 1'b0;
    chk("ss_state", int'(state_o), ST_DONE); chk("ss_time", int'(time_ms), 2);
    chk("ss_best", int'(best_ms), 2);

    start_and_wait_led();
    repeat (12) @(negedge clk);
    chk("mid_time", int'(time_ms), 3);
    #1 rst = 1'b0;
    #1 chk_reset_vals("rst_mid");
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("resume_state", int'(state_o), ST_IDLE);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 9) == 0);
      stop  = ($urandom_range(0, 29) == 0);
      clear = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 999) == 0) begin #1 rst = 1'b0; #2 rst = 1'b1; end
    end
    @(negedge clk); start = 1'b0; stop = 1'b0; clear = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/reaction_timer_n.md
REACTION_TIMER_N -- requirements
Module: reaction_timer_n

Interface
REQ-001 Parameter TICK_CYCLES, default 100000; clk cycles per 1 ms tick.
REQ-002 Parameter TW, default 10; width of time_ms and best_ms.
REQ-003 Parameter MAX_MS, default 1000; timeout limit in ms, SHALL be <= 2^TW-1.
REQ-004 Parameter DELAY_MIN_MS, default 2000; minimum random pre-stimulus delay.
REQ-005 Parameter DELAY_SPAN_LOG2, default 12; random delay span is 0..2^DELAY_SPAN_LOG2-1 ms.
REQ-006 clk  input  1  sole clock; all state changes on its rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  single-cycle pulse (upstream debounced): arm a trial.
REQ-009 stop  input  1  single-cycle pulse: player response.
REQ-010 clear  input  1  single-cycle pulse: abort/return to IDLE.
REQ-011 led  output  1  stimulus lamp, high only in RUN.
REQ-012 time_ms  output  TW  current/last reaction time, binary ms.
REQ-013 best_ms  output  TW  lowest valid time since reset; all-ones = none.
REQ-014 state_o  output  3  IDLE=0, WAIT=1, RUN=2, DONE=3, FAULT=4, TIMEOUT=5.
REQ-015 busy  output  1  high in WAIT or RUN.

Function
REQ-016 Input priority when pulses coincide in one cycle SHALL be clear > stop > start.
REQ-017 A 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) SHALL advance every cycle from seed 16'hACE1 and never reach zero.
REQ-018 Tick generator SHALL count 0..TICK_CYCLES-1 and emit a one-cycle tick at TICK_CYCLES-1; it SHALL restart from 0 on every entry to WAIT or RUN.
REQ-019 IDLE/DONE/FAULT/TIMEOUT + start -> WAIT; delay_ms latched = DELAY_MIN_MS + LFSR[DELAY_SPAN_LOG2-1:0]; time_ms cleared to 0.
REQ-020 WAIT: delay counter decrements per tick; on reaching 0 -> RUN next cycle, led rises in that same cycle.
REQ-021 WAIT + stop -> FAULT (false start); time_ms stays 0; best_ms unchanged.
REQ-022 RUN: time_ms increments by 1 on each tick; first increment TICK_CYCLES cycles after RUN entry.
REQ-023 RUN + stop -> DONE; time_ms frozen at value present that cycle (0 is valid); best_ms <= time_ms if time_ms < best_ms, same edge.
REQ-024 RUN and tick taking time_ms to MAX_MS -> TIMEOUT; time_ms holds MAX_MS; best_ms unchanged.
REQ-025 Stop coinciding with the timeout tick SHALL be treated as timeout (time already = MAX_MS, no best update).
REQ-026 start while in WAIT or RUN SHALL be ignored.
REQ-027 stop in IDLE, DONE, FAULT, TIMEOUT SHALL be ignored.
REQ-028 clear from any state -> IDLE; time_ms <= 0; led <= 0; best_ms retained.
REQ-029 All outputs SHALL be registered; state change visible one cycle after the triggering pulse.

Reset
REQ-030 rst low SHALL immediately force: state IDLE, led 0, time_ms 0, best_ms all-ones, busy 0, tick and delay counters 0, LFSR 16'hACE1.
REQ-031 Reset deassertion mid-trial SHALL resume in IDLE; no partial result retained.

Verification (TICK_CYCLES=4, MAX_MS=20, DELAY_MIN_MS=3, DELAY_SPAN_LOG2=2)
REQ-032 Reset, start, wait for led, stop after 7 ticks (28 cycles) -> state DONE, time_ms=7, best_ms=7, led 0.
REQ-033 Second trial stop at 5 ticks -> best_ms=5; third trial at 9 ticks -> time_ms=9, best_ms stays 5.
REQ-034 Start then stop during WAIT -> state FAULT, time_ms=0, led never high, best_ms unchanged.
REQ-035 Start, no stop -> TIMEOUT exactly 80 cycles after RUN entry, time_ms=20, best_ms unchanged.
REQ-036 Same-cycle clear+stop in RUN -> IDLE, time_ms=0, best unchanged; same-cycle stop+start in RUN -> DONE.
REQ-037 rst asserted in RUN at time_ms=3 -> outputs at reset values before next clk edge; delay latched at each start within 3..6 ms.
